// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: RegDst and forward-select encodings, control bundle
// and EX-stage payload layouts, and the immediate-extension helper.
package pipeline_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned ALUFUN_W   = 6;
  localparam int unsigned REGDST_W   = 2;
  localparam int unsigned MEMTOREG_W = 2;
  localparam int unsigned FWD_W      = 2;

  typedef enum logic [REGDST_W-1:0] {
    REGDST_RD = 2'd0,
    REGDST_RT = 2'd1,
    REGDST_RA = 2'd2,
    REGDST_XP = 2'd3
  } regdst_e;

  typedef enum logic [FWD_W-1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_EX   = 2'd2
  } fwd_e;

  typedef struct packed {
    logic [REGDST_W-1:0]   reg_dst;
    logic                  reg_wr;
    logic                  alu_src1;
    logic                  alu_src2;
    logic [ALUFUN_W-1:0]   alu_fun;
    logic                  sign;
    logic                  mem_wr;
    logic                  mem_rd;
    logic [MEMTOREG_W-1:0] mem_to_reg;
    logic                  ext_op;
    logic                  lu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [DATA_W-1:0] pc_plus;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  shamt;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  write_reg;
    fwd_e              fwd_a;
    fwd_e              fwd_b;
  } ex_t;

  // Upper-load, sign- or zero-extension of a 16-bit immediate
  function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm,
                                                input logic ext_op,
                                                input logic lu_op);
    if (lu_op)       return {imm, 16'h0000};
    else if (ext_op) return {{16{imm[15]}}, imm};
    else             return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/idex_stage_if.sv
// ID->EX stage bus: decoded ID inputs, MEM destination, EX outputs and hazard status.
interface idex_stage_if;
  import pipeline_pkg::*;

  logic [DATA_W-1:0]     id_Instr;
  logic [DATA_W-1:0]     id_PCplus;
  logic [DATA_W-1:0]     id_DatabusA;
  logic [DATA_W-1:0]     id_DatabusB;
  logic [REGDST_W-1:0]   id_RegDst;
  logic                  id_RegWr;
  logic                  id_ALUSrc1;
  logic                  id_ALUSrc2;
  logic [ALUFUN_W-1:0]   id_ALUFun;
  logic                  id_Sign;
  logic                  id_MemWr;
  logic                  id_MemRd;
  logic [MEMTOREG_W-1:0] id_MemtoReg;
  logic                  id_EXTOp;
  logic                  id_LUOp;
  logic                  flush;
  logic                  mem_RegWr;
  logic [REG_W-1:0]      mem_WriteReg;

  logic [REGDST_W-1:0]   ex_RegDst;
  logic                  ex_RegWr;
  logic                  ex_ALUSrc1;
  logic                  ex_ALUSrc2;
  logic [ALUFUN_W-1:0]   ex_ALUFun;
  logic                  ex_Sign;
  logic                  ex_MemWr;
  logic                  ex_MemRd;
  logic [MEMTOREG_W-1:0] ex_MemtoReg;
  logic                  ex_EXTOp;
  logic                  ex_LUOp;
  logic [DATA_W-1:0]     ex_PCplus;
  logic [DATA_W-1:0]     ex_A;
  logic [DATA_W-1:0]     ex_B;
  logic [DATA_W-1:0]     ex_Imm;
  logic [REG_W-1:0]      ex_Shamt;
  logic [REG_W-1:0]      ex_Rs;
  logic [REG_W-1:0]      ex_Rt;
  logic [REG_W-1:0]      ex_WriteReg;
  logic [FWD_W-1:0]      fwdA;
  logic [FWD_W-1:0]      fwdB;
  logic                  datahazard;
  logic [DATA_W-1:0]     stall_count;

  modport master (
    output id_Instr, id_PCplus, id_DatabusA, id_DatabusB, id_RegDst, id_RegWr,
           id_ALUSrc1, id_ALUSrc2, id_ALUFun, id_Sign, id_MemWr, id_MemRd,
           id_MemtoReg, id_EXTOp, id_LUOp, flush, mem_RegWr, mem_WriteReg,
    input  ex_RegDst, ex_RegWr, ex_ALUSrc1, ex_ALUSrc2, ex_ALUFun, ex_Sign,
           ex_MemWr, ex_MemRd, ex_MemtoReg, ex_EXTOp, ex_LUOp, ex_PCplus, ex_A,
           ex_B, ex_Imm, ex_Shamt, ex_Rs, ex_Rt, ex_WriteReg, fwdA, fwdB,
           datahazard, stall_count
  );

  modport slave (
    input  id_Instr, id_PCplus, id_DatabusA, id_DatabusB, id_RegDst, id_RegWr,
           id_ALUSrc1, id_ALUSrc2, id_ALUFun, id_Sign, id_MemWr, id_MemRd,
           id_MemtoReg, id_EXTOp, id_LUOp, flush, mem_RegWr, mem_WriteReg,
    output ex_RegDst, ex_RegWr, ex_ALUSrc1, ex_ALUSrc2, ex_ALUFun, ex_Sign,
           ex_MemWr, ex_MemRd, ex_MemtoReg, ex_EXTOp, ex_LUOp, ex_PCplus, ex_A,
           ex_B, ex_Imm, ex_Shamt, ex_Rs, ex_Rt, ex_WriteReg, fwdA, fwdB,
           datahazard, stall_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Combinational hazard detection and forward-select generation for the ID stage.
// With IDEX_FWD_EN defined only load-use stalls; otherwise any live EX/MEM RAW stalls.
module hazard_unit
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_reg_wr,
  input  logic             ex_mem_rd,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             mem_reg_wr,
  input  logic [REG_W-1:0] mem_write_reg,
  output logic             datahazard_c,
  output fwd_e             fwd_a_c,
  output fwd_e             fwd_b_c
);

  logic ex_live, mem_live, ex_hit, mem_hit, load_use;

  // Compare ID sources against EX/MEM destinations; $0 never matches
  always_comb begin
    ex_live  = ex_reg_wr && (ex_write_reg != '0);
    mem_live = mem_reg_wr && (mem_write_reg != '0);
    ex_hit   = (ex_write_reg == id_rs) || (ex_write_reg == id_rt);
    mem_hit  = (mem_write_reg == id_rs) || (mem_write_reg == id_rt);
    load_use = ex_mem_rd && (ex_write_reg != '0) && ex_hit;
    fwd_a_c  = FWD_NONE;
    fwd_b_c  = FWD_NONE;
`ifdef IDEX_FWD_EN
    datahazard_c = load_use;
    if (ex_live && (ex_write_reg == id_rs))        fwd_a_c = FWD_EX;
    else if (mem_live && (mem_write_reg == id_rs)) fwd_a_c = FWD_MEM;
    if (ex_live && (ex_write_reg == id_rt))        fwd_b_c = FWD_EX;
    else if (mem_live && (mem_write_reg == id_rt)) fwd_b_c = FWD_MEM;
`else
    datahazard_c = load_use || (ex_live && ex_hit) || (mem_live && mem_hit);
`endif
  end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register: extends the immediate, selects the EX destination,
// inserts bubbles on hazards or flushes and counts them (saturating).
// Optional forwarding selects enabled by defining IDEX_FWD_EN.
module idex_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned RA_REG = 31,
  parameter int unsigned XP_REG = 26
) (
  input logic         clk,
  input logic         reset,
  idex_stage_if.slave bus
);

  ex_t               ex_q, ex_d, id_ex_c;
  logic [DATA_W-1:0] stall_count_q, stall_count_d;
  logic              datahazard_c, bubble_c;
  fwd_e              fwd_a_c, fwd_b_c;
  logic [REG_W-1:0]  id_rs_c, id_rt_c;
  logic              unused_opcode;

  assign id_rs_c       = bus.id_Instr[25:21];
  assign id_rt_c       = bus.id_Instr[20:16];
  assign unused_opcode = ^bus.id_Instr[31:26];

  hazard_unit u_hazard (
    .id_rs         (id_rs_c),
    .id_rt         (id_rt_c),
    .ex_reg_wr     (ex_q.ctrl.reg_wr),
    .ex_mem_rd     (ex_q.ctrl.mem_rd),
    .ex_write_reg  (ex_q.write_reg),
    .mem_reg_wr    (bus.mem_RegWr),
    .mem_write_reg (bus.mem_WriteReg),
    .datahazard_c  (datahazard_c),
    .fwd_a_c       (fwd_a_c),
    .fwd_b_c       (fwd_b_c)
  );

  // Assemble the EX payload from the ID instruction and decoded controls
  always_comb begin
    id_ex_c                 = '0;
    id_ex_c.ctrl.reg_dst    = bus.id_RegDst;
    id_ex_c.ctrl.reg_wr     = bus.id_RegWr;
    id_ex_c.ctrl.alu_src1   = bus.id_ALUSrc1;
    id_ex_c.ctrl.alu_src2   = bus.id_ALUSrc2;
    id_ex_c.ctrl.alu_fun    = bus.id_ALUFun;
    id_ex_c.ctrl.sign       = bus.id_Sign;
    id_ex_c.ctrl.mem_wr     = bus.id_MemWr;
    id_ex_c.ctrl.mem_rd     = bus.id_MemRd;
    id_ex_c.ctrl.mem_to_reg = bus.id_MemtoReg;
    id_ex_c.ctrl.ext_op     = bus.id_EXTOp;
    id_ex_c.ctrl.lu_op      = bus.id_LUOp;
    id_ex_c.pc_plus         = bus.id_PCplus;
    id_ex_c.a               = bus.id_DatabusA;
    id_ex_c.b               = bus.id_DatabusB;
    id_ex_c.imm             = ext_imm(bus.id_Instr[15:0], bus.id_EXTOp, bus.id_LUOp);
    id_ex_c.shamt           = bus.id_Instr[10:6];
    id_ex_c.rs              = id_rs_c;
    id_ex_c.rt              = id_rt_c;
    id_ex_c.fwd_a           = fwd_a_c;
    id_ex_c.fwd_b           = fwd_b_c;
    case (regdst_e'(bus.id_RegDst))
      REGDST_RD: id_ex_c.write_reg = bus.id_Instr[15:11];
      REGDST_RT: id_ex_c.write_reg = id_rt_c;
      REGDST_RA: id_ex_c.write_reg = REG_W'(RA_REG);
      REGDST_XP: id_ex_c.write_reg = REG_W'(XP_REG);
    endcase
  end

  // Load the ID payload or a zeroed bubble; count bubbles, saturating at all-ones
  always_comb begin
    bubble_c      = datahazard_c || bus.flush;
    ex_d          = id_ex_c;
    stall_count_d = stall_count_q;
    if (bubble_c) begin
      ex_d = '0;
      if (stall_count_q != '1) stall_count_d = stall_count_q + DATA_W'(1);
    end
  end

  // Stage register and bubble counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q          <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.ex_RegDst   = ex_q.ctrl.reg_dst;
  assign bus.ex_RegWr    = ex_q.ctrl.reg_wr;
  assign bus.ex_ALUSrc1  = ex_q.ctrl.alu_src1;
  assign bus.ex_ALUSrc2  = ex_q.ctrl.alu_src2;
  assign bus.ex_ALUFun   = ex_q.ctrl.alu_fun;
  assign bus.ex_Sign     = ex_q.ctrl.sign;
  assign bus.ex_MemWr    = ex_q.ctrl.mem_wr;
  assign bus.ex_MemRd    = ex_q.ctrl.mem_rd;
  assign bus.ex_MemtoReg = ex_q.ctrl.mem_to_reg;
  assign bus.ex_EXTOp    = ex_q.ctrl.ext_op;
  assign bus.ex_LUOp     = ex_q.ctrl.lu_op;
  assign bus.ex_PCplus   = ex_q.pc_plus;
  assign bus.ex_A        = ex_q.a;
  assign bus.ex_B        = ex_q.b;
  assign bus.ex_Imm      = ex_q.imm;
  assign bus.ex_Shamt    = ex_q.shamt;
  assign bus.ex_Rs       = ex_q.rs;
  assign bus.ex_Rt       = ex_q.rt;
  assign bus.ex_WriteReg = ex_q.write_reg;
  assign bus.fwdA        = ex_q.fwd_a;
  assign bus.fwdB        = ex_q.fwd_b;
  assign bus.datahazard  = datahazard_c;
  assign bus.stall_count = stall_count_q;

endmodule
